dma_req_if: RTL and testbench

DMA_REQ_IF -- requirements
Module: dma_req_if

---
 rtl/dma_req_if_pkg.sv | 25 ++
 rtl/dma_req_chan.sv | 126 ++++++++++++
 rtl/dma_req_if.sv | 65 ++++++
 tb/tb_dma_req_if.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_req_if_pkg.sv
// -----------------------------------------------------------------------------
// dma_req_if_pkg
// Shared definitions for the peripheral DMA request interface:
//   - chan_state_t : per-channel handshake FSM states (IDLE, REQ, HOLD)
//   - chan_mode_t  : per-channel request mode encoding (level / pulse)
//   - default synchronizer depth, pending-counter width and channel count
// -----------------------------------------------------------------------------
package dma_req_if_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_PEND_W      = 4;
    localparam int NUM_CH          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } chan_state_t;

    typedef enum logic {
        MODE_LEVEL = 1'b0,   // 4-phase handshake on periph_req level
        MODE_PULSE = 1'b1    // each periph_req rising edge is one request
    } chan_mode_t;

endpackage

// File: rtl/dma_req_chan.sv
// -----------------------------------------------------------------------------
// dma_req_chan
// One DMA request channel: synchronizes an asynchronous peripheral request,
// detects its rising edges, counts pulse-mode requests and runs the
// request/acknowledge handshake towards the DMA controller.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   periph_req  : peripheral request (asynchronous to clk)
//   mode        : 0 = level, 1 = pulse; sampled only while IDLE
//   ack         : grant from the DMA controller (synchronous)
//   ovf_clr     : single-cycle clear of ovf
//   req         : registered request to the DMA controller
//   periph_ack  : registered acknowledge back to the peripheral
//   ovf         : sticky pending-counter overflow
// -----------------------------------------------------------------------------
module dma_req_chan
    import dma_req_if_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,   // legal 2..3
    parameter int PEND_W      = DEF_PEND_W
) (
    input  logic clk,
    input  logic rst,
    input  logic periph_req,
    input  logic mode,
    input  logic ack,
    input  logic ovf_clr,
    output logic req,
    output logic periph_ack,
    output logic ovf
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sreq_d;
    logic                   sreq;
    logic [PEND_W-1:0]      pend;
    chan_state_t            state;
    chan_mode_t             mode_q;
    chan_mode_t             eff_mode;
    logic                   inc;
    logic                   dec;
    logic                   sat;

    assign sreq = sync_q[SYNC_STAGES-1];

    // NOTE: async reset clears the synchronizer too, so a request that was
    // in flight when reset hit is simply forgotten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sreq_d <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage take the value
            // the previous stage held before this edge, forming a real chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], periph_req};
            sreq_d <= sreq;
        end
    end

    // While IDLE the live mode input applies; otherwise the value latched
    // when the current transfer started.
    assign eff_mode = (state == IDLE) ? chan_mode_t'(mode) : mode_q;
    assign sat      = &pend;
    assign inc      = sreq && !sreq_d && (eff_mode == MODE_PULSE);
    assign dec      = (state == REQ) && (mode_q == MODE_PULSE) && ack;

    // Pending counter: an edge and a grant in the same cycle cancel out,
    // and that case also never flags overflow even at saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else begin
            if (inc && !dec) begin
                if (!sat) pend <= pend + 1'b1;
            end else if (dec && !inc) begin
                pend <= pend - 1'b1;
            end

            if (inc && sat && !dec) ovf <= 1'b1;
            else if (ovf_clr)       ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= MODE_LEVEL;
            req        <= 1'b0;
            periph_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    periph_ack <= 1'b0;
                    mode_q     <= chan_mode_t'(mode);
                    if ((chan_mode_t'(mode) == MODE_LEVEL) ? sreq : (pend != '0)) begin
                        state <= REQ;
                        req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack) begin
                        req        <= 1'b0;
                        periph_ack <= 1'b1;
                        // Pulse mode returns through IDLE, which guarantees
                        // at least one cycle of req low between grants.
                        state      <= (mode_q == MODE_LEVEL) ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    if (!sreq) begin
                        periph_ack <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req        <= 1'b0;
                    periph_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dma_req_if.sv
// -----------------------------------------------------------------------------
// dma_req_if
// Four independent peripheral DMA request channels in front of the DMA
// controller's arbiter. Arbitration itself stays in the controller.
//
// Ports
//   HCLK, HRESET : clock, asynchronous active-high reset
//   periph_req   : [3:0] peripheral requests (asynchronous)
//   periph_ack   : [3:0] registered acknowledges to the peripherals
//   mode         : [3:0] per-channel mode, 0 = level, 1 = pulse
//   req_0..req_3 : registered requests to the controller
//   ack_0..ack_3 : grants from the controller
//   ovf          : [3:0] sticky pending-counter overflow
//   ovf_clr      : [3:0] single-cycle clear of ovf
// -----------------------------------------------------------------------------
module dma_req_if
    import dma_req_if_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int PEND_W      = DEF_PEND_W
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [NUM_CH-1:0] periph_req,
    output logic [NUM_CH-1:0] periph_ack,
    input  logic [NUM_CH-1:0] mode,
    output logic              req_0,
    output logic              req_1,
    output logic              req_2,
    output logic              req_3,
    input  logic              ack_0,
    input  logic              ack_1,
    input  logic              ack_2,
    input  logic              ack_3,
    output logic [NUM_CH-1:0] ovf,
    input  logic [NUM_CH-1:0] ovf_clr
);

    logic [NUM_CH-1:0] ack_v;
    logic [NUM_CH-1:0] req_v;

    assign ack_v = {ack_3, ack_2, ack_1, ack_0};
    assign req_0 = req_v[0];
    assign req_1 = req_v[1];
    assign req_2 = req_v[2];
    assign req_3 = req_v[3];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        dma_req_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .PEND_W      (PEND_W)
        ) u_chan (
            .clk        (HCLK),
            .rst        (HRESET),
            .periph_req (periph_req[i]),
            .mode       (mode[i]),
            .ack        (ack_v[i]),
            .ovf_clr    (ovf_clr[i]),
            .req        (req_v[i]),
            .periph_ack (periph_ack[i]),
            .ovf        (ovf[i])
        );
    end

endmodule

// File: tb/tb_dma_req_if.sv
// -----------------------------------------------------------------------------
// tb_dma_req_if
// Self-checking bench for dma_req_if: directed handshake, saturation,
// simultaneity and reset scenarios plus randomized pulse/level traffic,
// checked against request counts derived from the stimulus itself.
// -----------------------------------------------------------------------------
module tb_dma_req_if;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] periph_req;
    logic [3:0] periph_ack;
    logic [3:0] mode;
    logic       req_0, req_1, req_2, req_3;
    logic [3:0] ack_v;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;
    logic [3:0] req_v;

    assign req_v = {req_3, req_2, req_1, req_0};

    dma_req_if dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .periph_req (periph_req),
        .periph_ack (periph_ack),
        .mode       (mode),
        .req_0      (req_0),
        .req_1      (req_1),
        .req_2      (req_2),
        .req_3      (req_3),
        .ack_0      (ack_v[0]),
        .ack_1      (ack_v[1]),
        .ack_2      (ack_v[2]),
        .ack_3      (ack_v[3]),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Controller model: 0 = manual (ack_man), 1 = always grant,
    // 2 = random grant, 3 = grant one cycle after req is seen.
    int   ack_mode [4];
    logic [3:0] ack_man;

    always @(posedge HCLK) begin
        #2;
        for (int i = 0; i < 4; i++) begin
            case (ack_mode[i])
                0:       ack_v[i] = ack_man[i];
                1:       ack_v[i] = 1'b1;
                2:       ack_v[i] = 1'($urandom_range(0, 1));
                default: ack_v[i] = req_v[i];
            endcase
        end
    end

    // Monitor: transaction counts seen on the controller and peripheral sides.
    int grants [4];
    int pa_hi  [4];
    int pa_rise[4];
    bit pa_prev[4];

    always @(negedge HCLK) begin
        if (!HRESET) begin
            for (int i = 0; i < 4; i++) begin
                if (req_v[i] && ack_v[i]) grants[i]++;
                if (periph_ack[i]) pa_hi[i]++;
                if (periph_ack[i] && !pa_prev[i]) pa_rise[i]++;
            end
        end
        for (int i = 0; i < 4; i++) pa_prev[i] = periph_ack[i];
    end

    int g_base[4], hi_base[4], rise_base[4];

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            g_base[i]    = grants[i];
            hi_base[i]   = pa_hi[i];
            rise_base[i] = pa_rise[i];
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic pulse(input int ch, input int width);
        periph_req[ch] = 1'b1;
        repeat (width) tick();
        periph_req[ch] = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int npul[4], left[4], hi_left[4], gap[4];
    int ch, k;

    initial begin
        HRESET     = 1'b1;
        periph_req = '0;
        mode       = '0;
        ovf_clr    = '0;
        ack_man    = '0;
        for (int i = 0; i < 4; i++) ack_mode[i] = 0;
        repeat (3) tick();
        check("reset_req", 32'(req_v), 0);
        check("reset_pack", 32'(periph_ack), 0);
        check("reset_ovf", 32'(ovf), 0);
        HRESET = 1'b0;
        repeat (2) tick();

        // Level handshake on ch0: req after 3 cycles, ack held until 3 after drop.
        ack_mode[0] = 3;
        snap();
        periph_req[0] = 1'b1;
        tick(); tick();
        check("lvl_req_early", 32'(req_0), 0);
        tick();
        check("lvl_req_lat", 32'(req_0), 1);
        tick();
        check("lvl_req_drop", 32'(req_0), 0);
        check("lvl_pack_on", 32'(periph_ack[0]), 1);
        repeat (4) tick();
        check("lvl_pack_hold", 32'(periph_ack[0]), 1);
        periph_req[0] = 1'b0;
        tick(); tick();
        check("lvl_pack_stay", 32'(periph_ack[0]), 1);
        tick();
        check("lvl_pack_off", 32'(periph_ack[0]), 0);
        repeat (3) tick();
        check("lvl_grants", 32'(grants[0] - g_base[0]), 1);
        check("lvl_idle_req", 32'(req_0), 0);

        // Pulse mode ch1: five pulses, controller always granting.
        mode[1] = 1'b1;
        ack_mode[1] = 1;
        snap();
        for (int p = 0; p < 5; p++) pulse(1, 1);
        repeat (20) tick();
        check("pls_grants", 32'(grants[1] - g_base[1]), 5);
        check("pls_pack_rise", 32'(pa_rise[1] - rise_base[1]), 5);
        check("pls_pack_hi", 32'(pa_hi[1] - hi_base[1]), 5);
        check("pls_req_end", 32'(req_1), 0);

        // Saturation ch2: 17 pulses with no grant.
        mode[2] = 1'b1;
        ack_mode[2] = 0;
        snap();
        for (int p = 0; p < 17; p++) pulse(2, 1);
        repeat (3) tick();
        check("sat_req", 32'(req_2), 1);
        check("sat_ovf", 32'(ovf[2]), 1);
        check("sat_no_grant", 32'(grants[2] - g_base[2]), 0);
        ovf_clr[2] = 1'b1;
        tick();
        ovf_clr[2] = 1'b0;
        check("sat_ovf_clr", 32'(ovf[2]), 0);
        ack_mode[2] = 1;
        repeat (60) tick();
        check("sat_drain", 32'(grants[2] - g_base[2]), 15);
        check("sat_drain_pack", 32'(pa_rise[2] - rise_base[2]), 15);
        check("sat_req_end", 32'(req_2), 0);
        check("sat_ovf_end", 32'(ovf[2]), 0);

        // Simultaneous edge and grant on ch3 with one pending request.
        mode[3] = 1'b1;
        ack_mode[3] = 0;
        snap();
        pulse(3, 1);
        repeat (3) tick();
        check("sim_req_pend1", 32'(req_3), 1);
        periph_req[3] = 1'b1;
        tick();
        periph_req[3] = 1'b0;
        tick();
        ack_man[3] = 1'b1;
        tick();
        ack_man[3] = 1'b0;
        check("sim_gap_req", 32'(req_3), 0);
        check("sim_gap_pack", 32'(periph_ack[3]), 1);
        tick();
        check("sim_req_again", 32'(req_3), 1);
        check("sim_grants1", 32'(grants[3] - g_base[3]), 1);
        ack_mode[3] = 1;
        repeat (10) tick();
        check("sim_grants2", 32'(grants[3] - g_base[3]), 2);
        check("sim_req_end", 32'(req_3), 0);

        // Reset with ch0 in HOLD and ch1 holding three pending pulses.
        mode[0] = 1'b0;
        ack_mode[0] = 3;
        ack_mode[1] = 0;
        ack_man[1] = 1'b0;
        periph_req[0] = 1'b1;
        for (int p = 0; p < 3; p++) pulse(1, 1);
        repeat (3) tick();
        check("rst_pre_hold", 32'(periph_ack[0]), 1);
        check("rst_pre_req1", 32'(req_1), 1);
        #2;
        HRESET = 1'b1;
        periph_req[0] = 1'b0;
        #1;
        check("rst_req_zero", 32'(req_v), 0);
        check("rst_pack_zero", 32'(periph_ack), 0);
        check("rst_ovf_zero", 32'(ovf), 0);
        tick(); tick();
        HRESET = 1'b0;
        snap();
        repeat (12) tick();
        check("rst_no_req", 32'(req_v), 0);
        check("rst_no_pack", 32'(periph_ack), 0);
        check("rst_no_grant1", 32'(grants[1] - g_base[1]), 0);

        // Spurious grant on idle ch0.
        ack_mode[0] = 0;
        ack_man[0] = 1'b1;
        snap();
        repeat (5) tick();
        ack_man[0] = 1'b0;
        tick();
        check("spur_req", 32'(req_0), 0);
        check("spur_pack", 32'(periph_ack[0]), 0);
        check("spur_pack_cnt", 32'(pa_hi[0] - hi_base[0]), 0);

        // Random pulse traffic on all channels; each pulse must yield
        // exactly one grant and one single-cycle peripheral ack.
        for (int r = 0; r < 4; r++) begin
            mode = 4'hF;
            snap();
            for (int i = 0; i < 4; i++) begin
                npul[i]    = $urandom_range(0, 10);
                left[i]    = npul[i];
                hi_left[i] = 0;
                gap[i]     = $urandom_range(0, 5);
                ack_mode[i] = 2;
            end
            for (int c = 0; c < 200; c++) begin
                for (int i = 0; i < 4; i++) begin
                    if (hi_left[i] > 0) begin
                        hi_left[i]--;
                        if (hi_left[i] == 0) begin
                            periph_req[i] = 1'b0;
                            gap[i] = $urandom_range(3, 6);
                        end
                    end else if (gap[i] > 0) begin
                        gap[i]--;
                    end else if (left[i] > 0) begin
                        periph_req[i] = 1'b1;
                        hi_left[i] = $urandom_range(1, 2);
                        left[i]--;
                    end
                end
                tick();
            end
            for (int i = 0; i < 4; i++) ack_mode[i] = 1;
            repeat (40) tick();
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rnd%0d_grants_ch%0d", r, i), 32'(grants[i] - g_base[i]), 32'(npul[i]));
                check($sformatf("rnd%0d_pack_ch%0d", r, i), 32'(pa_hi[i] - hi_base[i]), 32'(npul[i]));
                check($sformatf("rnd%0d_ovf_ch%0d", r, i), 32'(ovf[i]), 0);
            end
            check($sformatf("rnd%0d_req_end", r), 32'(req_v), 0);
        end

        // Random level transactions with a randomly granting controller.
        mode = 4'h0;
        for (int i = 0; i < 4; i++) ack_mode[i] = 2;
        for (int t = 0; t < 8; t++) begin
            ch = $urandom_range(0, 3);
            snap();
            periph_req[ch] = 1'b1;
            k = 0;
            while (k < 60 && !periph_ack[ch]) begin
                tick();
                k++;
            end
            check($sformatf("lrnd%0d_ack", t), 32'(periph_ack[ch]), 1);
            repeat ($urandom_range(0, 4)) tick();
            periph_req[ch] = 1'b0;
            tick(); tick();
            check($sformatf("lrnd%0d_hold", t), 32'(periph_ack[ch]), 1);
            tick();
            check($sformatf("lrnd%0d_release", t), 32'(periph_ack[ch]), 0);
            repeat (3) tick();
            check($sformatf("lrnd%0d_grants", t), 32'(grants[ch] - g_base[ch]), 1);
            check($sformatf("lrnd%0d_req_end", t), 32'(req_v), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
